// File: rtl/rpsc_card_pkg.sv
// rpsc_card_pkg: shared types and constants for the card-12 fault qualifier.
// Channel indices map qualifier lanes onto the FF41..FF48 fault flip-flops.
package rpsc_card_pkg;

  localparam int CH_FF41 = 0;
  localparam int CH_FF42 = 1;
  localparam int CH_FF43 = 2;
  localparam int CH_FF44 = 3;
  localparam int CH_FF45 = 4;
  localparam int CH_FF46 = 5;
  localparam int CH_FF47 = 6;
  localparam int CH_FF48 = 7;

  // Width of the first-fault channel index
  localparam int FF_IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PEND_SET = 2'd1,
    FAULT    = 2'd2,
    PEND_CLR = 2'd3
  } qual_state_t;

endpackage

// File: rtl/rpsc_fault_filter_ch.sv
// rpsc_fault_filter_ch: one fault channel. Synchronises the raw line, then
// requires ASSERT_CYC consecutive high samples to qualify and DEASSERT_CYC
// consecutive low samples to release. An aborted qualification sets a sticky
// glitch flag. inhibit blanks the channel back to IDLE.
module rpsc_fault_filter_ch
  import rpsc_card_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int ASSERT_CYC   = 1000,
  parameter int DEASSERT_CYC = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic inhibit,
  input  logic glitch_clr,
  output logic qual,
  output logic rise,
  output logic glitch
);

  localparam logic [CNT_W-1:0] SET_TERM = CNT_W'(ASSERT_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_TERM = CNT_W'(DEASSERT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync_meta;
  logic             s;
  qual_state_t      state;
  qual_state_t      state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             rise_q;
  logic             rise_nxt;
  logic             glitch_set;

  // Two-flop synchroniser; keeps running through inhibit so s is fresh on release
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= 1'b0;
      s         <= 1'b0;
    end else begin
      sync_meta <= raw;
      s         <= sync_meta;
    end
  end

  // Persistence FSM next-state and counter; inhibit overrides every transition
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    rise_nxt   = 1'b0;
    glitch_set = 1'b0;
    if (inhibit) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (s) begin
            state_nxt = PEND_SET;
            cnt_nxt   = CNT_ONE;
          end
        end
        PEND_SET: begin
          if (!s) begin
            state_nxt  = IDLE;
            cnt_nxt    = '0;
            glitch_set = 1'b1;
          end else if (cnt == SET_TERM) begin
            state_nxt = FAULT;
            cnt_nxt   = '0;
            rise_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        FAULT: begin
          if (!s) begin
            state_nxt = PEND_CLR;
            cnt_nxt   = CNT_ONE;
          end
        end
        PEND_CLR: begin
          if (s) begin
            state_nxt = FAULT;
            cnt_nxt   = '0;
          end else if (cnt == CLR_TERM) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State, counter and registered rise pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      rise_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      rise_q <= rise_nxt;
    end
  end

  // Sticky glitch flag; a new glitch beats a simultaneous clear so no event is lost
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      glitch <= 1'b0;
    end else if (glitch_set) begin
      glitch <= 1'b1;
    end else if (glitch_clr) begin
      glitch <= 1'b0;
    end
  end

  // Qualified level and pulse are blanked in the same cycle inhibit is raised
  assign qual = ((state == FAULT) || (state == PEND_CLR)) && !inhibit;
  assign rise = rise_q && !inhibit;

endmodule

// File: rtl/rpsc_fault_qualifier.sv
// rpsc_fault_qualifier: conditioning stage ahead of the card-12 fault
// flip-flops FF41..FF48. One rpsc_fault_filter_ch per line, plus an optional
// first-fault capture enabled by the RPSC_FIRST_FAULT_EN macro. Without the
// macro, ff_valid/ff_idx read 0 and ff_clr is ignored (pins kept for layout).
module rpsc_fault_qualifier
  import rpsc_card_pkg::*;
#(
  parameter int N_CH         = 8,
  parameter int CNT_W        = 16,
  parameter int ASSERT_CYC   = 1000,
  parameter int DEASSERT_CYC = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_CH-1:0]     raw_in,
  input  logic                inhibit,
  input  logic                glitch_clr,
  output logic [N_CH-1:0]     qual_out,
  output logic [N_CH-1:0]     qual_rise,
  output logic [N_CH-1:0]     glitch_flag,
  output logic                ff_valid,
  output logic [FF_IDX_W-1:0] ff_idx,
  input  logic                ff_clr
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    rpsc_fault_filter_ch #(
      .CNT_W        (CNT_W),
      .ASSERT_CYC   (ASSERT_CYC),
      .DEASSERT_CYC (DEASSERT_CYC)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .raw        (raw_in[g]),
      .inhibit    (inhibit),
      .glitch_clr (glitch_clr),
      .qual       (qual_out[g]),
      .rise       (qual_rise[g]),
      .glitch     (glitch_flag[g])
    );
  end

`ifdef RPSC_FIRST_FAULT_EN
  logic [FF_IDX_W-1:0] low_idx;

  // Lowest-numbered channel among this cycle's rise pulses
  always_comb begin
    low_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (qual_rise[i]) begin
        low_idx = FF_IDX_W'(i);
      end
    end
  end

  // First-fault record: a rise arriving with ff_clr is captured rather than dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ff_valid <= 1'b0;
      ff_idx   <= '0;
    end else if ((ff_clr || !ff_valid) && (|qual_rise)) begin
      ff_valid <= 1'b1;
      ff_idx   <= low_idx;
    end else if (ff_clr) begin
      ff_valid <= 1'b0;
      ff_idx   <= '0;
    end
  end
`else
  logic unused_ff_clr;

  assign unused_ff_clr = ff_clr;
  assign ff_valid      = 1'b0;
  assign ff_idx        = '0;
`endif

endmodule

// File: tb/tb_rpsc_fault_qualifier.sv
// tb_rpsc_fault_qualifier: directed scenarios plus randomized traffic, all
// checked against a run-length reference model of the qualifier.
module tb_rpsc_fault_qualifier;

  localparam int A_CYC = 4;
  localparam int D_CYC = 4;
`ifdef RPSC_FIRST_FAULT_EN
  localparam bit FF_EN = 1'b1;
`else
  localparam bit FF_EN = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] raw_in;
  logic       inhibit;
  logic       glitch_clr;
  logic [7:0] qual_out;
  logic [7:0] qual_rise;
  logic [7:0] glitch_flag;
  logic       ff_valid;
  logic [2:0] ff_idx;
  logic       ff_clr;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [7:0] m_d1, m_d2, m_q, m_rise, m_glitch;
  int         m_ones [8];
  int         m_zeros[8];
  logic       m_ffv;
  logic [2:0] m_ffi;

  rpsc_fault_qualifier #(
    .N_CH         (8),
    .CNT_W        (16),
    .ASSERT_CYC   (A_CYC),
    .DEASSERT_CYC (D_CYC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .raw_in      (raw_in),
    .inhibit     (inhibit),
    .glitch_clr  (glitch_clr),
    .qual_out    (qual_out),
    .qual_rise   (qual_rise),
    .glitch_flag (glitch_flag),
    .ff_valid    (ff_valid),
    .ff_idx      (ff_idx),
    .ff_clr      (ff_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_d1 = '0; m_d2 = '0; m_q = '0; m_rise = '0; m_glitch = '0;
    m_ffv = 1'b0; m_ffi = '0;
    for (int c = 0; c < 8; c++) begin
      m_ones[c]  = 0;
      m_zeros[c] = 0;
    end
  endtask

  // One clock edge of the model: line must be seen high A_CYC samples in a row
  // to qualify and low D_CYC samples in a row to release, two edges after raw_in.
  task automatic model_edge();
    logic [7:0] s;
    logic [7:0] rise_out;
    logic       found;
    s        = m_d2;
    m_d2     = m_d1;
    m_d1     = raw_in;
    rise_out = m_rise & ~{8{inhibit}};
    found    = 1'b0;
    if (FF_EN && (ff_clr || !m_ffv) && (rise_out != 8'h00)) begin
      m_ffv = 1'b1;
      for (int i = 0; i < 8; i++) begin
        if (rise_out[i] && !found) begin
          m_ffi = 3'(i);
          found = 1'b1;
        end
      end
    end else if (FF_EN && ff_clr) begin
      m_ffv = 1'b0;
    end
    for (int c = 0; c < 8; c++) begin
      logic new_rise;
      logic new_glitch;
      new_rise   = 1'b0;
      new_glitch = 1'b0;
      if (inhibit) begin
        m_ones[c]  = 0;
        m_zeros[c] = 0;
        m_q[c]     = 1'b0;
      end else if (!m_q[c]) begin
        if (s[c]) begin
          m_ones[c]++;
          if (m_ones[c] == A_CYC) begin
            m_q[c]    = 1'b1;
            m_ones[c] = 0;
            new_rise  = 1'b1;
          end
        end else begin
          if (m_ones[c] > 0) new_glitch = 1'b1;
          m_ones[c] = 0;
        end
      end else begin
        if (!s[c]) begin
          m_zeros[c]++;
          if (m_zeros[c] == D_CYC) begin
            m_q[c]     = 1'b0;
            m_zeros[c] = 0;
          end
        end else begin
          m_zeros[c] = 0;
        end
      end
      m_rise[c] = new_rise;
      if (new_glitch) m_glitch[c] = 1'b1;
      else if (glitch_clr) m_glitch[c] = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_edge();
    #1;
  endtask

  task automatic test_reset();
    raw_in = 8'hFF;
    reset  = 1'b0;
    #1 reset = 1'b1;
    #2;
    checks++;
    if (qual_out !== 8'h00) begin
      errors++; $display("[TB] FAIL reset_async_qual: got %h expected %h", qual_out, 8'h00);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (qual_out !== 8'h00) begin
      errors++; $display("[TB] FAIL reset_qual: got %h expected %h", qual_out, 8'h00);
    end
    checks++;
    if (qual_rise !== 8'h00) begin
      errors++; $display("[TB] FAIL reset_rise: got %h expected %h", qual_rise, 8'h00);
    end
    checks++;
    if (glitch_flag !== 8'h00) begin
      errors++; $display("[TB] FAIL reset_glitch: got %h expected %h", glitch_flag, 8'h00);
    end
    checks++;
    if (ff_valid !== 1'b0 || ff_idx !== 3'd0) begin
      errors++; $display("[TB] FAIL reset_ff: got %b/%0d expected 0/0", ff_valid, ff_idx);
    end
    reset = 1'b0;
    model_reset();
    for (int e = 1; e <= 7; e++) begin
      tick();
      checks++;
      if (qual_out !== ((e >= 6) ? 8'hFF : 8'h00)) begin
        errors++; $display("[TB] FAIL latency_qual edge %0d: got %h expected %h", e, qual_out, (e >= 6) ? 8'hFF : 8'h00);
      end
      checks++;
      if (qual_rise !== ((e == 6) ? 8'hFF : 8'h00)) begin
        errors++; $display("[TB] FAIL latency_rise edge %0d: got %h expected %h", e, qual_rise, (e == 6) ? 8'hFF : 8'h00);
      end
    end
    checks++;
    if (ff_valid !== FF_EN || ff_valid !== m_ffv) begin
      errors++; $display("[TB] FAIL reset_first_fault: got %b expected %b", ff_valid, FF_EN);
    end
    raw_in = 8'h00;
    repeat (8) tick();
    checks++;
    if (qual_out !== 8'h00) begin
      errors++; $display("[TB] FAIL reset_release: got %h expected %h", qual_out, 8'h00);
    end
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 9; i++) begin
      raw_in = (i < 3) ? 8'h04 : 8'h00;
      tick();
      checks++;
      if (qual_out[2] !== 1'b0 || qual_out !== (m_q & ~{8{inhibit}})) begin
        errors++; $display("[TB] FAIL glitch_no_qual cyc %0d: got %h expected %h", i, qual_out, 8'h00);
      end
    end
    checks++;
    if (glitch_flag !== 8'h04 || glitch_flag !== m_glitch) begin
      errors++; $display("[TB] FAIL glitch_set: got %h expected %h", glitch_flag, 8'h04);
    end
    glitch_clr = 1'b1;
    tick();
    glitch_clr = 1'b0;
    checks++;
    if (glitch_flag !== 8'h00) begin
      errors++; $display("[TB] FAIL glitch_clear: got %h expected %h", glitch_flag, 8'h00);
    end
    // Clear pulse lands on the same edge that records a new glitch on channel 1
    for (int i = 0; i < 7; i++) begin
      raw_in     = (i < 2) ? 8'h02 : 8'h00;
      glitch_clr = (i == 4);
      tick();
    end
    glitch_clr = 1'b0;
    checks++;
    if (glitch_flag !== 8'h02 || glitch_flag !== m_glitch) begin
      errors++; $display("[TB] FAIL glitch_clr_collision: got %h expected %h", glitch_flag, 8'h02);
    end
    glitch_clr = 1'b1;
    tick();
    glitch_clr = 1'b0;
  endtask

  task automatic test_hold();
    raw_in = 8'h01;
    repeat (6) tick();
    checks++;
    if (qual_out !== 8'h01 || qual_rise !== 8'h01) begin
      errors++; $display("[TB] FAIL hold_qualify: got %h/%h expected 01/01", qual_out, qual_rise);
    end
    for (int i = 0; i < 10; i++) begin
      raw_in = (i < 2) ? 8'h00 : 8'h01;
      tick();
      checks++;
      if (qual_out[0] !== 1'b1 || qual_rise[0] !== 1'b0) begin
        errors++; $display("[TB] FAIL hold_dropout cyc %0d: got %b/%b expected 1/0", i, qual_out[0], qual_rise[0]);
      end
    end
    raw_in = 8'h00;
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++;
      if (qual_out[0] !== ((k == 6) ? 1'b0 : 1'b1)) begin
        errors++; $display("[TB] FAIL hold_release edge %0d: got %b expected %b", k, qual_out[0], (k == 6) ? 1'b0 : 1'b1);
      end
    end
  endtask

  task automatic test_inhibit();
    inhibit = 1'b1;
    raw_in  = 8'h81;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (qual_out !== 8'h00 || qual_rise !== 8'h00) begin
        errors++; $display("[TB] FAIL inhibit_blank cyc %0d: got %h/%h expected 00/00", i, qual_out, qual_rise);
      end
    end
    inhibit = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (qual_out !== ((k == 4) ? 8'h81 : 8'h00)) begin
        errors++; $display("[TB] FAIL inhibit_release edge %0d: got %h expected %h", k, qual_out, (k == 4) ? 8'h81 : 8'h00);
      end
    end
    inhibit = 1'b1;
    #1;
    checks++;
    if (qual_out !== 8'h00 || qual_rise !== 8'h00) begin
      errors++; $display("[TB] FAIL inhibit_same_cycle: got %h/%h expected 00/00", qual_out, qual_rise);
    end
    tick();
    checks++;
    if (qual_out !== 8'h00 || glitch_flag !== m_glitch) begin
      errors++; $display("[TB] FAIL inhibit_forced_idle: got %h/%h expected 00/%h", qual_out, glitch_flag, m_glitch);
    end
    inhibit = 1'b0;
    raw_in  = 8'h00;
    repeat (8) tick();
    checks++;
    if (qual_out !== 8'h00 || glitch_flag !== m_glitch) begin
      errors++; $display("[TB] FAIL inhibit_cleanup: got %h/%h expected 00/%h", qual_out, glitch_flag, m_glitch);
    end
  endtask

  task automatic test_first_fault();
    ff_clr = 1'b1;
    tick();
    ff_clr = 1'b0;
    checks++;
    if (ff_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL ff_rearm: got %b expected 0", ff_valid);
    end
    raw_in = 8'h28;
    repeat (7) tick();
    checks++;
    if (ff_valid !== FF_EN || ff_idx !== (FF_EN ? 3'd3 : 3'd0)) begin
      errors++; $display("[TB] FAIL ff_simultaneous: got %b/%0d expected %b/%0d", ff_valid, ff_idx, FF_EN, FF_EN ? 3 : 0);
    end
    raw_in = 8'h2A;
    repeat (7) tick();
    checks++;
    if (ff_valid !== FF_EN || ff_idx !== (FF_EN ? 3'd3 : 3'd0)) begin
      errors++; $display("[TB] FAIL ff_hold: got %b/%0d expected %b/%0d", ff_valid, ff_idx, FF_EN, FF_EN ? 3 : 0);
    end
    raw_in = 8'h6A;
    repeat (6) tick();
    checks++;
    if (qual_rise !== 8'h40) begin
      errors++; $display("[TB] FAIL ff_ch6_rise: got %h expected %h", qual_rise, 8'h40);
    end
    ff_clr = 1'b1;
    tick();
    ff_clr = 1'b0;
    checks++;
    if (ff_valid !== FF_EN || ff_idx !== (FF_EN ? 3'd6 : 3'd0) || ff_valid !== m_ffv) begin
      errors++; $display("[TB] FAIL ff_clr_with_rise: got %b/%0d expected %b/%0d", ff_valid, ff_idx, FF_EN, FF_EN ? 6 : 0);
    end
    raw_in = 8'h00;
    repeat (8) tick();
  endtask

  task automatic test_async_reset();
    raw_in = 8'h10;
    repeat (4) tick();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (qual_out !== 8'h00 || qual_rise !== 8'h00 || glitch_flag !== 8'h00 || ff_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL async_reset: got %h/%h/%h/%b expected all zero", qual_out, qual_rise, glitch_flag, ff_valid);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++;
      if (qual_out !== ((k == 6) ? 8'h10 : 8'h00)) begin
        errors++; $display("[TB] FAIL async_restart edge %0d: got %h expected %h", k, qual_out, (k == 6) ? 8'h10 : 8'h00);
      end
    end
    raw_in = 8'h00;
    repeat (8) tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      for (int c = 0; c < 8; c++) begin
        if ($urandom_range(0, 5) == 0) raw_in[c] = ~raw_in[c];
      end
      inhibit    = ($urandom_range(0, 39) == 0);
      glitch_clr = ($urandom_range(0, 19) == 0);
      ff_clr     = ($urandom_range(0, 14) == 0);
      tick();
      checks++;
      if (qual_out !== (m_q & ~{8{inhibit}})) begin
        errors++; $display("[TB] FAIL rand_qual cyc %0d: got %h expected %h", n, qual_out, m_q & ~{8{inhibit}});
      end
      checks++;
      if (qual_rise !== (m_rise & ~{8{inhibit}})) begin
        errors++; $display("[TB] FAIL rand_rise cyc %0d: got %h expected %h", n, qual_rise, m_rise & ~{8{inhibit}});
      end
      checks++;
      if (glitch_flag !== m_glitch) begin
        errors++; $display("[TB] FAIL rand_glitch cyc %0d: got %h expected %h", n, glitch_flag, m_glitch);
      end
      checks++;
      if (ff_valid !== m_ffv) begin
        errors++; $display("[TB] FAIL rand_ff_valid cyc %0d: got %b expected %b", n, ff_valid, m_ffv);
      end
      if (m_ffv) begin
        checks++;
        if (ff_idx !== m_ffi) begin
          errors++; $display("[TB] FAIL rand_ff_idx cyc %0d: got %0d expected %0d", n, ff_idx, m_ffi);
        end
      end
    end
    inhibit    = 1'b0;
    glitch_clr = 1'b0;
    ff_clr     = 1'b0;
  endtask

  initial begin
    reset      = 1'b0;
    raw_in     = 8'h00;
    inhibit    = 1'b0;
    glitch_clr = 1'b0;
    ff_clr     = 1'b0;
    model_reset();
    test_reset();
    test_glitch();
    test_hold();
    test_inhibit();
    test_first_fault();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
